// File: rtl/commit_trace_fifo_pkg.sv
// Shared types for the commit trace observer: FSM states and the trace entry layout.
package commit_trace_fifo_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned TRACE_W = 3 * XLEN;

  // Capture FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HALTED  = 2'd2
  } state_e;

  // One retired-instruction sample; pc lands in [95:64], inst in [63:32], r in [31:0].
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] r;
  } trace_t;

endpackage

// File: rtl/commit_trace_fifo_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: clk, rst_n (sync, active-low), push/wdata, pop, rdata (head, combinational),
//        count (0..DEPTH), full, empty (both registered).
// A push while full is accepted when a pop happens on the same edge.
module commit_trace_fifo_sync_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             pop_ok_c;
  logic             push_ok_c;
  logic [CW-1:0]    count_next_c;

  // Pop needs data present; push needs room, which a same-edge pop provides.
  assign pop_ok_c  = pop && !empty;
  assign push_ok_c = push && (!full || pop_ok_c);

  // Occupancy after this edge.
  always_comb begin
    count_next_c = count;
    case ({push_ok_c, pop_ok_c})
      2'b10:   count_next_c = count + CW'(1);
      2'b01:   count_next_c = count - CW'(1);
      default: count_next_c = count;
    endcase
  end

  // Pointers and occupancy flags; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok_c)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next_c;
      full  <= (count_next_c == CW'(DEPTH));
      empty <= (count_next_c == '0);
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/commit_trace_fifo.sv
// Commit trace observer: samples {PC, INST, R} each cycle while capturing, buffers it
// in a FWFT FIFO drained over a valid/ready port, counts samples and drops, and
// freezes capture when the PC self-loops HALT_REPEAT times.
// Ports: CLK, RST_N (sync, active-low), EN, PC/INST/R (CPU trace), RD_READY,
//        RD_VALID/RD_PC/RD_INST/RD_R (head), COUNT, FULL, EMPTY, INST_CNT, DROP_CNT, HALTED.
module commit_trace_fifo
  import commit_trace_fifo_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AW          = 4,
  parameter int unsigned HALT_REPEAT = 3
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            EN,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] INST,
  input  logic [XLEN-1:0] R,
  input  logic            RD_READY,
  output logic            RD_VALID,
  output logic [XLEN-1:0] RD_PC,
  output logic [XLEN-1:0] RD_INST,
  output logic [XLEN-1:0] RD_R,
  output logic [AW:0]     COUNT,
  output logic            FULL,
  output logic            EMPTY,
  output logic [31:0]     INST_CNT,
  output logic [15:0]     DROP_CNT,
  output logic            HALTED
);

  localparam int unsigned RW = $clog2(HALT_REPEAT + 1);

  state_e          state_q;
  state_e          state_next_c;
  logic [RW-1:0]   rep_q;
  logic [RW-1:0]   rep_next_c;
  logic [XLEN-1:0] last_pc_q;
  logic [31:0]     inst_cnt_q;
  logic [15:0]     drop_cnt_q;
  logic            sample_c;
  logic            pop_c;
  logic            push_c;
  logic            drop_c;
  logic            halt_hit_c;
  trace_t          wr_entry_c;
  trace_t          head_c;

  // Sample / push / drop decision for this edge.
  assign sample_c   = (state_q == ST_CAPTURE) && EN;
  assign pop_c      = !EMPTY && RD_READY;
  assign push_c     = sample_c && (!FULL || pop_c);
  assign drop_c     = sample_c && !push_c;
  assign wr_entry_c = '{pc: PC, inst: INST, r: R};

  // Self-loop run length; held at HALT_REPEAT so it cannot wrap.
  always_comb begin
    rep_next_c = '0;
    if (PC == last_pc_q) begin
      rep_next_c = (rep_q == RW'(HALT_REPEAT)) ? rep_q : rep_q + RW'(1);
    end
  end

  assign halt_hit_c = sample_c && (rep_next_c == RW'(HALT_REPEAT));

  // Capture FSM next state.
  always_comb begin
    state_next_c = state_q;
    case (state_q)
      ST_IDLE:    if (EN) state_next_c = ST_CAPTURE;
      ST_CAPTURE: begin
        if (!EN)            state_next_c = ST_IDLE;
        else if (halt_hit_c) state_next_c = ST_HALTED;
      end
      ST_HALTED:  if (!EN) state_next_c = ST_IDLE;
      default:    state_next_c = ST_IDLE;
    endcase
  end

  // Capture FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_next_c;
  end

  // Halt detector history and sample/drop counters.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rep_q      <= '0;
      last_pc_q  <= '0;
      inst_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else if (sample_c) begin
      rep_q      <= rep_next_c;
      last_pc_q  <= PC;
      inst_cnt_q <= inst_cnt_q + 32'(1);
      if (drop_c && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'(1);
    end
  end

  commit_trace_fifo_sync_fifo #(
    .WIDTH (TRACE_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push_c),
    .wdata (wr_entry_c),
    .pop   (pop_c),
    .rdata (head_c),
    .count (COUNT),
    .full  (FULL),
    .empty (EMPTY)
  );

  assign RD_VALID = !EMPTY;
  assign RD_PC    = head_c.pc;
  assign RD_INST  = head_c.inst;
  assign RD_R     = head_c.r;
  assign INST_CNT = inst_cnt_q;
  assign DROP_CNT = drop_cnt_q;
  assign HALTED   = (state_q == ST_HALTED);

endmodule
